// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-requester mux arbiter.
// The optional grant-timeout feature is enabled by defining MUX_ARB_TIMEOUT_EN.
package mux_arb_pkg;

  localparam int HOLD_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mux2_w.sv
// DATA_W-wide 2:1 multiplexer; cntrl=1 selects in2, cntrl=0 selects in1.
module mux2_w #(
  parameter int DATA_W = 8
) (
  output logic [DATA_W-1:0] out,
  input  logic              cntrl,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2
);

  assign out = cntrl ? in2 : in1;

endmodule

// File: rtl/mux_arbiter2.sv
// Round-robin arbiter for two requesters sharing one registered-select mux.
// Define MUX_ARB_TIMEOUT_EN to force a handoff after MAX_HOLD cycles of contention.
module mux_arbiter2
  import mux_arb_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              cntrl,
  output logic [DATA_W-1:0] out,
  output logic              out_valid
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("mux_arbiter2: MAX_HOLD must lie in 1..255");
  end

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic              last;
  logic              hold_expired;
  logic [DATA_W-1:0] mux_out;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam logic [HOLD_CNT_W-1:0] HOLD_LIMIT = HOLD_CNT_W'(MAX_HOLD - 1);

  logic [HOLD_CNT_W-1:0] hold_cnt;

  assign hold_expired = (hold_cnt == HOLD_LIMIT);

  // Cleared on every grant entry; saturates at the limit so a late rival
  // request is served on the very next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (state_nxt == IDLE || state_nxt != state) begin
      hold_cnt <= '0;
    end else if (!hold_expired) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  assign hold_expired = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req0 && req1) state_nxt = last ? GRANT0 : GRANT1;
        else if (req0)    state_nxt = GRANT0;
        else if (req1)    state_nxt = GRANT1;
        else              state_nxt = IDLE;
      end
      GRANT0: begin
        if (req0 && !(hold_expired && req1)) state_nxt = GRANT0;
        else if (req1)                       state_nxt = GRANT1;
        else                                 state_nxt = IDLE;
      end
      GRANT1: begin
        if (req1 && !(hold_expired && req0)) state_nxt = GRANT1;
        else if (req0)                       state_nxt = GRANT0;
        else                                 state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // last resets to 1 so requester 0 wins the first tie; cntrl holds in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      cntrl <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      gnt0  <= (state_nxt == GRANT0);
      gnt1  <= (state_nxt == GRANT1);
      if (state_nxt == GRANT0) begin
        cntrl <= 1'b0;
        last  <= 1'b0;
      end else if (state_nxt == GRANT1) begin
        cntrl <= 1'b1;
        last  <= 1'b1;
      end
    end
  end

  mux2_w #(
    .DATA_W(DATA_W)
  ) u_mux (
    .out  (mux_out),
    .cntrl(cntrl),
    .in1  (in0),
    .in2  (in1)
  );

  assign out_valid = gnt0 | gnt1;
  assign out       = out_valid ? mux_out : '0;

endmodule

// File: tb/tb_mux_arbiter2.sv
// Directed scoreboard bench for mux_arbiter2 (MAX_HOLD=4); follows
// MUX_ARB_TIMEOUT_EN to pick the expected contention behaviour.
module tb_mux_arbiter2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b1;
  logic       req1 = 1'b1;
  logic [7:0] in0 = 8'h11;
  logic [7:0] in1 = 8'h22;
  logic       gnt0;
  logic       gnt1;
  logic       cntrl;
  logic [7:0] out;
  logic       out_valid;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    string      tag;
    logic       g0;
    logic       g1;
    logic       c;
    logic [7:0] o;
  } exp_t;

  exp_t sb[$];

  mux_arbiter2 #(
    .DATA_W  (8),
    .MAX_HOLD(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .req1     (req1),
    .in0      (in0),
    .in1      (in1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .cntrl    (cntrl),
    .out      (out),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check_out();
    exp_t e;
    n_checks++;
    assert (sb.size() != 0) else begin
      n_fails++;
      $error("FAIL scoreboard_empty observed=0 entries expected>=1");
      return;
    end
    e = sb.pop_front();
    n_checks++;
    assert (gnt0 === e.g0) else begin
      n_fails++;
      $error("FAIL %s.gnt0 observed=%b expected=%b", e.tag, gnt0, e.g0);
    end
    n_checks++;
    assert (gnt1 === e.g1) else begin
      n_fails++;
      $error("FAIL %s.gnt1 observed=%b expected=%b", e.tag, gnt1, e.g1);
    end
    n_checks++;
    assert (cntrl === e.c) else begin
      n_fails++;
      $error("FAIL %s.cntrl observed=%b expected=%b", e.tag, cntrl, e.c);
    end
    n_checks++;
    assert (out === e.o) else begin
      n_fails++;
      $error("FAIL %s.out observed=%h expected=%h", e.tag, out, e.o);
    end
    n_checks++;
    assert (out_valid === (e.g0 | e.g1)) else begin
      n_fails++;
      $error("FAIL %s.out_valid observed=%b expected=%b", e.tag, out_valid, e.g0 | e.g1);
    end
  endtask

  // Drive one cycle of inputs, record what must be visible after the edge, check it.
  task automatic step(input string tag, input logic r, input logic r0, input logic r1,
                      input logic [7:0] d0, input logic [7:0] d1,
                      input logic eg0, input logic eg1, input logic ec);
    exp_t e;
    @(negedge clk);
    rst  = r;
    req0 = r0;
    req1 = r1;
    in0  = d0;
    in1  = d1;
    e.tag = tag;
    e.g0  = eg0;
    e.g1  = eg1;
    e.c   = ec;
    e.o   = eg0 ? d0 : (eg1 ? d1 : 8'h00);
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    // Reset held two cycles with both requests high
    step("rst_a", 1, 1, 1, 8'h11, 8'h22, 0, 0, 0);
    step("rst_b", 1, 1, 1, 8'h11, 8'h22, 0, 0, 0);
    step("rst_release_tie", 0, 1, 1, 8'h11, 8'h22, 1, 0, 0);
    step("to_idle", 0, 0, 0, 8'h11, 8'h22, 0, 0, 0);

    // Single requester 1
    step("single1_grant", 0, 0, 1, 8'h11, 8'hA5, 0, 1, 1);
    step("single1_live_in", 0, 0, 1, 8'h11, 8'h5A, 0, 1, 1);
    step("single1_drop", 0, 0, 0, 8'h11, 8'hA5, 0, 0, 1);

    // Tie, direct handoff, round-robin
    step("tie_grant0", 0, 1, 1, 8'h3C, 8'hA5, 1, 0, 0);
    step("handoff_to1", 0, 0, 1, 8'h3C, 8'hA5, 0, 1, 1);
    step("idle_gap", 0, 0, 0, 8'h3C, 8'hA5, 0, 0, 1);
    step("rr_tie_grant0", 0, 1, 1, 8'hC3, 8'h77, 1, 0, 0);
    step("back_idle", 0, 0, 0, 8'hC3, 8'h77, 0, 0, 0);

    // Contention while requester 0 holds the grant
    step("hold0_entry", 0, 1, 0, 8'h01, 8'h02, 1, 0, 0);
    for (int i = 0; i < 3; i++) step("hold0_contend", 0, 1, 1, 8'h01, 8'h02, 1, 0, 0);
`ifdef MUX_ARB_TIMEOUT_EN
    step("timeout_switch", 0, 1, 1, 8'h01, 8'h02, 0, 1, 1);
    step("timeout_idle", 0, 0, 0, 8'h01, 8'h02, 0, 0, 1);
    step("long0_entry", 0, 1, 0, 8'h40, 8'h41, 1, 0, 0);
    for (int i = 0; i < 22; i++) step("long0_hold", 0, 1, 0, 8'h40, 8'h41, 1, 0, 0);
    step("saturated_switch", 0, 1, 1, 8'h40, 8'h41, 0, 1, 1);
`else
    for (int i = 0; i < 6; i++) step("no_timeout_hold", 0, 1, 1, 8'h01, 8'h02, 1, 0, 0);
    step("long0_continue", 0, 1, 0, 8'h40, 8'h41, 1, 0, 0);
    for (int i = 0; i < 22; i++) step("long0_hold", 0, 1, 0, 8'h40, 8'h41, 1, 0, 0);
    step("release0_to1", 0, 0, 1, 8'h40, 8'h41, 0, 1, 1);
`endif

    // Reset in the middle of a requester 1 grant
    step("midgrant_rst", 1, 1, 1, 8'h55, 8'h66, 0, 0, 0);
    step("post_rst_tie", 0, 1, 1, 8'h55, 8'h66, 1, 0, 0);

    n_checks++;
    assert (sb.size() == 0) else begin
      n_fails++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mux_arbiter2.md
MUX_ARBITER2 -- requirements
Module: mux_arbiter2

Interface
REQ-001 Parameter DATA_W, default 8: width of each data input and of the output.
REQ-002 Parameter MAX_HOLD, default 15: maximum grant tenure in cycles when the timeout feature is compiled in; legal range 1..255.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port req0, input, 1: requester 0 wants the shared output.
REQ-006 Port req1, input, 1: requester 1 wants the shared output.
REQ-007 Port in0, input, DATA_W: requester 0 data.
REQ-008 Port in1, input, DATA_W: requester 1 data.
REQ-009 Port gnt0, output, 1: requester 0 owns the output; registered.
REQ-010 Port gnt1, output, 1: requester 1 owns the output; registered.
REQ-011 Port cntrl, output, 1: mux select; 1 selects in1, 0 selects in0; registered.
REQ-012 Port out, output, DATA_W: the selected input's data when a grant is active, otherwise all zeros.
REQ-013 Port out_valid, output, 1: equals gnt0 | gnt1.

Function
REQ-014 The FSM SHALL have three states: IDLE, GRANT0 and GRANT1; gnt0 is 1 only in GRANT0 and gnt1 is 1 only in GRANT1; gnt0 and gnt1 are never both 1.
REQ-015 Grant latency SHALL be one cycle: a request sampled at edge N produces a grant visible after edge N.
REQ-016 From IDLE: req0 only -> GRANT0; req1 only -> GRANT1; both -> the requester other than last; neither -> IDLE.
REQ-017 From GRANTn with reqn=1 (and no forced switch per REQ-023), the FSM SHALL stay in GRANTn.
REQ-018 From GRANTn with reqn=0: the other request high -> GRANTm directly, with no IDLE bubble; otherwise -> IDLE.
REQ-019 Register last SHALL record the index of the most recently granted requester, updated on each entry to a grant state.
REQ-020 cntrl SHALL equal 1 in GRANT1, 0 in GRANT0, and hold its previous value in IDLE.
REQ-021 out SHALL be combinational from the registered state and the live in0/in1, with no added latency.

Reset
REQ-022 While rst=1 at an edge, including mid-grant, the block SHALL set state=IDLE, gnt0=0, gnt1=0, cntrl=0, last=1 (so req0 wins the first tie), hold counter=0, out=0 and out_valid=0; requests are ignored during that cycle.

Configuration
REQ-023 With MUX_ARB_TIMEOUT_EN defined, an 8-bit hold counter SHALL clear on grant entry and increment each cycle in GRANTn; when the counter reaches MAX_HOLD-1 while the other request is high, the next state SHALL be GRANTm even if reqn=1.
REQ-024 With MUX_ARB_TIMEOUT_EN defined, if the counter reaches the limit and the other request is low, the counter SHALL saturate and the grant SHALL hold.
REQ-025 Without MUX_ARB_TIMEOUT_EN, the hold counter SHALL be absent and the grant SHALL be held for as long as reqn=1.

Structure
REQ-026 Package mux_arb_pkg SHALL hold the state enum type (IDLE, GRANT0, GRANT1) and the counter width constant HOLD_CNT_W=8.
REQ-027 The datapath SHALL be one sub-module, mux2_w: a DATA_W-wide 2:1 mux with ports out, cntrl, in1, in2; mux_arbiter2 gates its output to zero when out_valid=0.

Verification
REQ-028 Reset: rst=1 for 2 cycles with req0=req1=1 -> gnt0=gnt1=0, out=0, cntrl=0; after release, gnt0=1 one cycle later.
REQ-029 Single requester: req1=1 with in1=8'hA5 -> next cycle gnt1=1, cntrl=1, out=8'hA5; drop req1 -> next cycle IDLE, out=0, cntrl stays 1.
REQ-030 Tie and handoff: req0=req1=1 from IDLE -> GRANT0; drop req0 -> GRANT1 on the next edge with no IDLE cycle; then drop req1 and raise both -> GRANT0 (round-robin).
REQ-031 Timeout (macro on, MAX_HOLD=4): req0 held high, req1 raised -> gnt0 for exactly 4 cycles, then gnt1; with req1 low, gnt0 holds for 20 or more cycles.
REQ-032 Timeout absent (macro off): same stimulus as REQ-031 -> gnt0 holds until req0 drops.
REQ-033 Mid-grant reset: rst=1 for one cycle during GRANT1 -> IDLE next cycle; with both requests still high, the next grant is gnt0.
